// File: rtl/rom_reader_pkg.sv
// Shared constants for rom_reader: FSM state encoding, FIFO depth and the read credit limit.
package rom_reader_pkg;

    localparam int FIFO_DEPTH   = 4;
    localparam int FIFO_AW      = $clog2(FIFO_DEPTH);
    localparam int CREDIT_LIMIT = FIFO_DEPTH;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t FETCH  = 2'd1;
    localparam state_t DRAIN  = 2'd2;
    localparam state_t FINISH = 2'd3;

endpackage

// File: rtl/rom_reader_fifo.sv
// Small synchronous FIFO holding fetched words (data plus last flag) until the stream consumer takes them.
module rom_reader_fifo
    import rom_reader_pkg::*;
#(
    parameter int W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic             empty,
    output logic [FIFO_AW:0] count
);

    logic [W-1:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;

    // The writer never pushes into a full FIFO, so no full guard is applied here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/rom_reader.sv
// Block reader for synchronous-read memories: fetches len words from base and streams them on valid/ready.
// Define ROM_READER_CSUM_EN to enable the running XOR checksum on csum; otherwise csum is tied to 0.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic [AW-1:0]    mem_adr,
    input  logic [WIDTH-1:0] mem_dat,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [WIDTH-1:0] csum
);

    state_t             state;
    logic [AW:0]        len_reg;
    logic [AW:0]        issue_cnt;
    logic [AW:0]        out_cnt;
    logic [AW-1:0]      adr;
    logic               pend;
    logic               pend_last;
    logic [AW:0]        len_eff;
    logic               issue_last;
    logic               out_last;
    logic               hs;
    logic [FIFO_AW:0]   fifo_count;
    logic [FIFO_AW+1:0] held;
    logic               fifo_empty;
    logic [WIDTH:0]     head;

    assign len_eff    = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign issue_last = (issue_cnt == len_reg - 1'b1);
    assign out_last   = (out_cnt == len_reg - 1'b1);
    assign hs         = m_valid & m_ready;

    // A read still in the memory pipeline counts against the FIFO space it will occupy.
    assign held   = {1'b0, fifo_count} + (FIFO_AW+2)'(pend);
    assign mem_en = (state == FETCH) && (issue_cnt != len_reg) &&
                    (held < (FIFO_AW+2)'(CREDIT_LIMIT));
    assign mem_adr = adr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_reg   <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
            adr       <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend      <= mem_en;
            pend_last <= mem_en & issue_last;
            if (hs) begin
                out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_reg   <= len_eff;
                        adr       <= base;
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        state     <= (len_eff == '0) ? FINISH : FETCH;
                    end
                end
                FETCH: begin
                    if (mem_en) begin
                        adr       <= (adr == AW'(DEPTH - 1)) ? '0 : adr + 1'b1;
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (hs && out_last) begin
                        state <= FINISH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rom_reader_fifo #(
        .W(WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pend),
        .wr_data ({pend_last, mem_dat}),
        .rd_en   (hs),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid = ~fifo_empty;
    assign m_data  = head[WIDTH-1:0];
    assign m_last  = m_valid & head[WIDTH];

    // For non-empty transfers done coincides with the final handshake, so FINISH is already idle-looking.
    assign done = ((state == FINISH) && (len_reg == '0)) ||
                  ((state == DRAIN) && hs && out_last);
    assign busy = (state == FETCH) || (state == DRAIN) ||
                  ((state == FINISH) && (len_reg == '0));

`ifdef ROM_READER_CSUM_EN
    logic [WIDTH-1:0] csum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else if ((state == IDLE) && start) begin
            csum_q <= '0;
        end else if (hs) begin
            csum_q <= csum_q ^ m_data;
        end
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader paired with a 16-word rom holding mem[i] = i ^ 8'hA5.
module tb_rom_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base = '0;
    logic [AW:0]      len = '0;
    logic             busy;
    logic             done;
    logic             mem_en;
    logic [AW-1:0]    mem_adr;
    logic [WIDTH-1:0] mem_dat = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [WIDTH-1:0] csum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    rom_reader #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (base),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .mem_en  (mem_en),
        .mem_adr (mem_adr),
        .mem_dat (mem_dat),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .csum    (csum)
    );

    // Behavioural rom with one cycle of read latency
    logic [7:0] romMem [DEPTH];

    always @(posedge clk) begin
        if (mem_en) mem_dat <= romMem[mem_adr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, filled at the falling edge and cleared per transfer
    int obsData[$];
    int obsLast[$];
    int adrLog[$];
    int doneCount, doneCyc, lastHsCyc, busyCount, busyFirst, firstValid;
    int creditViol, stallViol, issued, hsCnt, doneCsum;
    logic       prevStall;
    logic [7:0] prevData;
    logic       prevLast;

    task automatic clearMonitor();
        obsData.delete();
        obsLast.delete();
        adrLog.delete();
        doneCount = 0; doneCyc = -1; lastHsCyc = -1; busyCount = 0; busyFirst = -1;
        firstValid = -1; creditViol = 0; stallViol = 0; issued = 0; hsCnt = 0;
        doneCsum = -1; prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mem_en) begin
                if (issued - hsCnt >= 4) creditViol++;
                issued++;
                adrLog.push_back(int'(mem_adr));
            end
            if (prevStall && (!m_valid || m_data != prevData || m_last != prevLast)) stallViol++;
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            prevLast  = m_last;
            if (m_valid && firstValid < 0) firstValid = cyc;
            if (busy) begin
                busyCount++;
                if (busyFirst < 0) busyFirst = cyc;
            end
            if (m_valid && m_ready) begin
                obsData.push_back(int'(m_data));
                obsLast.push_back(int'(m_last));
                hsCnt++;
                lastHsCyc = cyc;
            end
            if (done) begin
                doneCount++;
                doneCyc  = cyc;
                doneCsum = int'(csum);
            end
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One transfer from request to completion, checked against the arithmetic reference
    task automatic applyStimulus(input int b, input int l, input int readyPct, input bit repulse);
        int  n;
        int  startCyc;
        int  expWord;
        int  expAdr;
        int  expCs;
        bit  finished;
        n = (l > DEPTH) ? DEPTH : l;
        @(posedge clk); #1;
        clearMonitor();
        start    = 1'b1;
        base     = AW'(b);
        len      = (AW+1)'(l);
        startCyc = cyc;
        m_ready  = ($urandom_range(99) < readyPct);
        finished = 1'b0;
        for (int k = 0; k < 300 && !finished; k++) begin
            @(posedge clk); #1;
            if (doneCount > 0) finished = 1'b1;
            m_ready = ($urandom_range(99) < readyPct);
            if (repulse && k == 3) begin
                start = 1'b1;
                base  = AW'(9);
                len   = (AW+1)'(2);
            end else begin
                start = 1'b0;
                base  = AW'($urandom);
                len   = (AW+1)'($urandom_range(31));
            end
        end
        @(posedge clk); #1;
        start   = 1'b0;
        m_ready = 1'b0;
        checkOutput("timeout", int'(finished), 1);
        if (finished) begin
            checkOutput("word_count", obsData.size(), n);
            checkOutput("read_count", adrLog.size(), n);
            expCs = 0;
            for (int i = 0; i < n; i++) begin
                expAdr  = (b + i) % DEPTH;
                expWord = expAdr ^ 8'hA5;
                expCs   = expCs ^ expWord;
                if (i < obsData.size()) begin
                    checkOutput($sformatf("data[%0d]", i), obsData[i], expWord);
                    checkOutput($sformatf("last[%0d]", i), obsLast[i], (i == n - 1) ? 1 : 0);
                end
                if (i < adrLog.size()) checkOutput($sformatf("adr[%0d]", i), adrLog[i], expAdr);
            end
            checkOutput("done_count", doneCount, 1);
            checkOutput("done_cycle", doneCyc, (n == 0) ? startCyc + 1 : lastHsCyc);
            checkOutput("busy_first", busyFirst, startCyc + 1);
            checkOutput("busy_cycles", busyCount, doneCyc - startCyc);
            if (n > 0) begin
                checkOutput("first_valid", firstValid, startCyc + 3);
                if (readyPct >= 100) checkOutput("no_bubbles", lastHsCyc - firstValid, n - 1);
            end else begin
                checkOutput("no_valid", firstValid, -1);
            end
            checkOutput("credit_viol", creditViol, 0);
            checkOutput("stall_viol", stallViol, 0);
`ifdef ROM_READER_CSUM_EN
            checkOutput("csum_done", doneCsum, expCs);
`else
            checkOutput("csum_done", doneCsum, 0);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) romMem[i] = 8'(i) ^ 8'hA5;
        clearMonitor();
        #12;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_mem_en", int'(mem_en), 0);
        checkOutput("rst_mem_adr", int'(mem_adr), 0);
        checkOutput("rst_m_valid", int'(m_valid), 0);
        checkOutput("rst_m_data", int'(m_data), 0);
        checkOutput("rst_m_last", int'(m_last), 0);
        checkOutput("rst_csum", int'(csum), 0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(3, 4, 100, 1'b0);
        applyStimulus(14, 4, 100, 1'b0);
        applyStimulus(0, 0, 100, 1'b0);
        applyStimulus(0, 16, 50, 1'b0);
        applyStimulus(0, 16, 60, 1'b1);
        applyStimulus(2, 25, 70, 1'b0);
        for (int t = 0; t < 6; t++) begin
            applyStimulus(int'($urandom_range(15)), int'($urandom_range(20)),
                          int'($urandom_range(20, 100)), 1'b0);
        end

        // Reset while two words sit in the FIFO and the consumer stalls
        @(posedge clk); #1;
        clearMonitor();
        start   = 1'b1;
        base    = '0;
        len     = (AW+1)'(16);
        m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_rst_valid", int'(m_valid), 1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", int'(m_valid), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_mem_en", int'(mem_en), 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(5, 1, 100, 1'b0);
        applyStimulus(0, 4, 100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
